cordic_rr_scheduler: RTL and testbench
======================================

// Module: cordic_rr_scheduler
// PURPOSE
// - Shares one pipelined CORDIC core (fixed-latency, no stall) among NUM_REQ requesters.
// - Round-robin arbitration; issues at most one operation per cycle.
// - Tags each issued op with its requester ID and routes the core result back to that requester.
// - Checks that core out_valid arrives exactly when the tag pipe expects it.
// PARAMETERS
// NUM_REQ      4   number of requesters (2..8)
// WIDTH        16  x/y operand and result width
// PHASE_WIDTH  19  phase width, 3.16 signed radians
// LATENCY      11  core cycles from enable to out_valid (= STAGES+3)
// ISSUE_SKEW   1   cycles after enable at which the core samples operands (0..2)
// PORTS
// in_clk         in   1                 clock, rising edge
// in_rst         in   1                 reset, asynchronous, active-low
// req_valid      in   NUM_REQ           per-requester request valid
// req_ready      out  NUM_REQ           one-hot grant; the request is accepted when valid&ready
// req_x          in   NUM_REQ*WIDTH     packed x operands, requester k at [k*WIDTH +: WIDTH]
// req_y          in   NUM_REQ*WIDTH     packed y operands
// req_phase      in   NUM_REQ*PHASE_WIDTH  packed phase operands
// rsp_valid      out  NUM_REQ           one-hot result strobe, 1 cycle, no backpressure
// rsp_x          out  WIDTH             result x, shared by all requesters, qualified by rsp_valid
// rsp_y          out  WIDTH             result y
// rsp_phase      out  PHASE_WIDTH       result phase
// cordic_enable  out  1                 in_enable pulse to the core
// cordic_x       out  WIDTH             operands to the core
// cordic_y       out  WIDTH
// cordic_phase   out  PHASE_WIDTH
// cordic_valid   in   1                 core out_valid
// cordic_rx      in   WIDTH             core out_x
// cordic_ry      in   WIDTH             core out_y
// cordic_rphase  in   PHASE_WIDTH       core out_phase
// inflight       out  $clog2(LATENCY+2) number of ops issued and not yet returned
// err_sticky     out  1                 set on a tag/valid mismatch; cleared only by reset
// BEHAVIOUR
// - Reset: all outputs 0; RR pointer = 0; tag pipe and operand delay line cleared.
//   Asserting in_rst mid-operation discards all in-flight ops and raises no rsp_valid.
// - Arbitration: req_ready is combinational from req_valid and the pointer.
//   - Scan starts at the pointer; the first k with req_valid[k] wins.
//   - After acceptance of k, the pointer becomes (k+1) mod NUM_REQ. With no request, the pointer holds.
//   - Requests are never refused, so the core accepts 1 op per cycle.
// - Issue timing:
//   - Accept in cycle t; cordic_enable=1 in t+1, registered.
//   - Operands pass through an ISSUE_SKEW-deep register line and are valid on cordic_x/y/phase at t+1+ISSUE_SKEW.
//   - The operands hold their value until the next issue overwrites them.
// - Tag pipe: a LATENCY-deep shift register of {vld, id[$clog2(NUM_REQ)-1:0]}.
//   - It is pushed alongside cordic_enable and its tail aligns with cordic_valid.
// - Response: at the tail cycle, if tail.vld and cordic_valid:
//   - next cycle, rsp_valid[tail.id]=1;
//   - rsp_x/y/phase hold the registered core results.
//   - Accept-to-response latency = LATENCY+2 cycles.
// - Mismatch: tail.vld XOR cordic_valid sets err_sticky; no rsp_valid is raised for that slot.
// - inflight: +1 on accept, -1 on tail.vld. On the same cycle both apply (net 0).
//   - Maximum value is LATENCY+1; it never wraps.
// - Arithmetic: pure routing; no operand modification and no sign extension.
// STRUCTURE
// - Shared package cordic_pkg holds:
//   - ATAN_FMT constants (PHASE_WIDTH=19, 3 integer bits);
//   - a tag struct typedef {logic vld; logic [2:0] id;};
//   - a function for LATENCY = STAGES+3.
// - One sub-module, rr_arbiter (NUM_REQ): req vector plus advance strobe in; one-hot grant and id out; owns the pointer.
// - The tag pipe, operand delay line, response register and counter stay in this module.
// TESTING (NUM_REQ=4, LATENCY=11, ISSUE_SKEW=1, with the core model)
// - Single op: req 2 with x=0x1000,y=0,phase=0x0C90F (pi/4 rot) -> enable at t+1.
//   - rsp_valid=4'b0100 at t+13, rsp_x~=rsp_y~=0x0B50.
// - All four held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//   - rsp_valid follows the same order, back-to-back; inflight peaks at 8 and returns to 0.
// - Pointer at 3 with req_valid=4'b1001 -> grant 3, then 0 next cycle; with 4'b0000 the pointer stays.
// - Accept and a returning result in the same cycle -> inflight unchanged; correct id routed.
// - Drop cordic_valid on one expected slot -> err_sticky=1, that rsp suppressed, later ops still routed.
// - Reset low while 5 ops are in flight -> all outputs 0 next edge; no rsp_valid after release; inflight=0.

Source files
------------

// File: rtl/cordic_rr_scheduler_pkg.sv
// Shared constants and types for the CORDIC round-robin scheduler.
// Phase format is 3.16 signed radians; tags carry up to 8 requester ids.
package cordic_rr_scheduler_pkg;

  localparam int unsigned AtanIntBits    = 3;
  localparam int unsigned AtanFracBits   = 16;
  localparam int unsigned AtanPhaseWidth = AtanIntBits + AtanFracBits;

  localparam int unsigned CordicStages = 8;
  localparam int unsigned MaxIdWidth   = 3;

  typedef struct packed {
    logic                  vld;
    logic [MaxIdWidth-1:0] id;
  } tag_t;

  // Core pipeline depth: input register, rotation stages, gain/output registers.
  function automatic int unsigned cordic_latency(input int unsigned stages);
    return stages + 3;
  endfunction

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Requester-side bus of the scheduler: packed operands in, shared results out.
interface cordic_rr_scheduler_if
  import cordic_rr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PHASE_WIDTH = AtanPhaseWidth
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*WIDTH-1:0]       req_x;
  logic [NUM_REQ*WIDTH-1:0]       req_y;
  logic [NUM_REQ*PHASE_WIDTH-1:0] req_phase;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [WIDTH-1:0]               rsp_x;
  logic [WIDTH-1:0]               rsp_y;
  logic [PHASE_WIDTH-1:0]         rsp_phase;

  modport master (
    output req_valid, req_x, req_y, req_phase,
    input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_phase
  );

  modport slave (
    input  req_valid, req_x, req_y, req_phase,
    output req_ready, rsp_valid, rsp_x, rsp_y, rsp_phase
  );

endinterface

// File: rtl/cordic_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: scan starts at the pointer, first valid request wins,
// pointer moves past the winner on advance and holds otherwise.
module rr_arbiter
  import cordic_rr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_valid
);

  localparam int unsigned IdWidth  = $clog2(NUM_REQ);
  localparam int unsigned SumWidth = IdWidth + 1;

  logic [IdWidth-1:0]  ptr_q, ptr_d;
  logic [SumWidth-1:0] sum;
  logic [IdWidth-1:0]  idx;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + SumWidth'(i);
      if (sum >= SumWidth'(NUM_REQ)) begin
        sum = sum - SumWidth'(NUM_REQ);
      end
      idx = sum[IdWidth-1:0];
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = (grant_id == IdWidth'(NUM_REQ - 1)) ? '0 : grant_id + IdWidth'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one fixed-latency CORDIC core among NUM_REQ requesters; tags each
// issued op with its requester id and routes the core result back to it.
module cordic_rr_scheduler
  import cordic_rr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PHASE_WIDTH = AtanPhaseWidth,
  parameter int unsigned LATENCY     = cordic_latency(CordicStages),
  parameter int unsigned ISSUE_SKEW  = 1
) (
  input  logic                            in_clk,
  input  logic                            in_rst,
  cordic_rr_scheduler_if.slave            bus,
  output logic                            cordic_enable,
  output logic [WIDTH-1:0]                cordic_x,
  output logic [WIDTH-1:0]                cordic_y,
  output logic [PHASE_WIDTH-1:0]          cordic_phase,
  input  logic                            cordic_valid,
  input  logic [WIDTH-1:0]                cordic_rx,
  input  logic [WIDTH-1:0]                cordic_ry,
  input  logic [PHASE_WIDTH-1:0]          cordic_rphase,
  output logic [$clog2(LATENCY+2)-1:0]    inflight,
  output logic                            err_sticky
);

  localparam int unsigned IdWidth  = $clog2(NUM_REQ);
  localparam int unsigned CntWidth = $clog2(LATENCY + 2);

  logic [NUM_REQ-1:0] grant;
  logic [IdWidth-1:0] grant_id;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .req         (bus.req_valid),
    .advance     (accept),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (accept)
  );

  assign bus.req_ready = grant;

  logic [WIDTH-1:0]       sel_x, sel_y;
  logic [PHASE_WIDTH-1:0] sel_phase;

  always_comb begin
    sel_x     = bus.req_x[grant_id*WIDTH +: WIDTH];
    sel_y     = bus.req_y[grant_id*WIDTH +: WIDTH];
    sel_phase = bus.req_phase[grant_id*PHASE_WIDTH +: PHASE_WIDTH];
  end

  // Stage 0 captures at accept and holds; later stages only add skew.
  logic [WIDTH-1:0]       opx_q [ISSUE_SKEW+1];
  logic [WIDTH-1:0]       opy_q [ISSUE_SKEW+1];
  logic [PHASE_WIDTH-1:0] opp_q [ISSUE_SKEW+1];

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i <= int'(ISSUE_SKEW); i++) begin
        opx_q[i] <= '0;
        opy_q[i] <= '0;
        opp_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        opx_q[0] <= sel_x;
        opy_q[0] <= sel_y;
        opp_q[0] <= sel_phase;
      end
      for (int i = 1; i <= int'(ISSUE_SKEW); i++) begin
        opx_q[i] <= opx_q[i-1];
        opy_q[i] <= opy_q[i-1];
        opp_q[i] <= opp_q[i-1];
      end
    end
  end

  assign cordic_x     = opx_q[ISSUE_SKEW];
  assign cordic_y     = opy_q[ISSUE_SKEW];
  assign cordic_phase = opp_q[ISSUE_SKEW];

  // issue_q is the enable-cycle tag; tag_q follows it so the tail lines up
  // with core out_valid LATENCY cycles after cordic_enable.
  tag_t issue_d, issue_q;
  tag_t tag_q [LATENCY];
  tag_t tail;

  always_comb begin
    issue_d     = '0;
    issue_d.vld = accept;
    issue_d.id  = MaxIdWidth'(grant_id);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      issue_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      issue_q  <= issue_d;
      tag_q[0] <= issue_q;
      for (int i = 1; i < int'(LATENCY); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign cordic_enable = issue_q.vld;
  assign tail          = tag_q[LATENCY-1];

  logic                   rsp_hit, mismatch;
  logic [NUM_REQ-1:0]     rsp_valid_d, rsp_valid_q;
  logic [WIDTH-1:0]       rsp_x_q, rsp_y_q;
  logic [PHASE_WIDTH-1:0] rsp_phase_q;
  logic [CntWidth-1:0]    inflight_d, inflight_q;
  logic                   err_q;

  always_comb begin
    rsp_hit     = tail.vld & cordic_valid;
    mismatch    = tail.vld ^ cordic_valid;
    rsp_valid_d = rsp_hit ? (NUM_REQ'(1) << tail.id) : '0;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, tail.vld})
      2'b10:   inflight_d = inflight_q + CntWidth'(1);
      2'b01:   inflight_d = inflight_q - CntWidth'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      rsp_valid_q <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_phase_q <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (rsp_hit) begin
        rsp_x_q     <= cordic_rx;
        rsp_y_q     <= cordic_ry;
        rsp_phase_q <= cordic_rphase;
      end
      inflight_q <= inflight_d;
      err_q      <= err_q | mismatch;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_x     = rsp_x_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_phase = rsp_phase_q;
  assign inflight      = inflight_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Scoreboard bench for cordic_rr_scheduler with a fixed-latency core model
// that samples operands ISSUE_SKEW cycles after enable.
module tb_cordic_rr_scheduler;

  localparam int N       = 4;
  localparam int W       = 16;
  localparam int PW      = 19;
  localparam int LAT     = 11;
  localparam int SKEW    = 1;
  localparam int RSP_LAT = LAT + 2;
  localparam int CW      = $clog2(LAT + 2);

  typedef struct {
    int            id;
    int            due;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [PW-1:0] ph;
  } exp_t;

  logic in_clk = 1'b0;
  logic in_rst = 1'b0;

  logic          cordic_enable;
  logic [W-1:0]  cordic_x, cordic_y;
  logic [PW-1:0] cordic_phase;
  logic          cordic_valid;
  logic [W-1:0]  cordic_rx, cordic_ry;
  logic [PW-1:0] cordic_rphase;
  logic [CW-1:0] inflight;
  logic          err_sticky;

  cordic_rr_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .PHASE_WIDTH(PW)) bus ();

  cordic_rr_scheduler #(
    .NUM_REQ     (N),
    .WIDTH       (W),
    .PHASE_WIDTH (PW),
    .LATENCY     (LAT),
    .ISSUE_SKEW  (SKEW)
  ) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .bus           (bus),
    .cordic_enable (cordic_enable),
    .cordic_x      (cordic_x),
    .cordic_y      (cordic_y),
    .cordic_phase  (cordic_phase),
    .cordic_valid  (cordic_valid),
    .cordic_rx     (cordic_rx),
    .cordic_ry     (cordic_ry),
    .cordic_rphase (cordic_rphase),
    .inflight      (inflight),
    .err_sticky    (err_sticky)
  );

  always #5 in_clk = ~in_clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic acc_hist[64];
  int   inf_m    = 0;
  bit   drop_req = 1'b0;

  logic          core_en[64];
  logic          core_v[64];
  logic [W-1:0]  core_x[64];
  logic [W-1:0]  core_y[64];
  logic [PW-1:0] core_p[64];

  always @(posedge in_clk) cyc <= cyc + 1;

  // Toy core transfer function: the scheduler only routes, so any distinct map works.
  function automatic logic [W-1:0] core_fx(input logic [W-1:0] x);
    return x ^ 16'h5A5A;
  endfunction
  function automatic logic [W-1:0] core_fy(input logic [W-1:0] x, input logic [W-1:0] y);
    return y + x;
  endfunction
  function automatic logic [PW-1:0] core_fp(input logic [PW-1:0] p);
    return p ^ 19'h70000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [PW-1:0] p);
    bus.req_x[k*W +: W]       = x;
    bus.req_y[k*W +: W]       = y;
    bus.req_phase[k*PW +: PW] = p;
  endtask

  // One cycle of stimulus; exp_rdy is the hand-derived round-robin grant.
  task automatic drive(input logic [N-1:0] vld, input logic [N-1:0] exp_rdy, input bit push);
    exp_t e;
    bus.req_valid = vld;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (exp_rdy != '0) begin
      acc_hist[cyc % 64] = 1'b1;
      if (push) begin
        for (int g = 0; g < N; g++) begin
          if (exp_rdy[g]) begin
            e.id  = g;
            e.due = cyc + RSP_LAT;
            e.x   = core_fx(bus.req_x[g*W +: W]);
            e.y   = core_fy(bus.req_x[g*W +: W], bus.req_y[g*W +: W]);
            e.ph  = core_fp(bus.req_phase[g*PW +: PW]);
            sb.push_back(e);
          end
        end
      end
    end
    @(posedge in_clk);
    #1;
    bus.req_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 4'b0000, 1'b0);
  endtask

  // Core model: fixed latency from enable, operands sampled SKEW cycles later.
  initial begin
    int s, k;
    cordic_valid  = 1'b0;
    cordic_rx     = '0;
    cordic_ry     = '0;
    cordic_rphase = '0;
    forever begin
      @(posedge in_clk);
      #1;
      if (!in_rst) begin
        for (int i = 0; i < 64; i++) begin
          core_en[i] = 1'b0;
          core_v[i]  = 1'b0;
        end
        cordic_valid = 1'b0;
      end else begin
        if (cordic_enable) core_en[cyc % 64] = 1'b1;
        s = (cyc + 64 - SKEW) % 64;
        if (core_en[s]) begin
          core_en[s] = 1'b0;
          k          = (s + LAT) % 64;
          core_v[k]  = 1'b1;
          core_x[k]  = core_fx(cordic_x);
          core_y[k]  = core_fy(cordic_x, cordic_y);
          core_p[k]  = core_fp(cordic_phase);
        end
        k            = cyc % 64;
        cordic_valid = 1'b0;
        if (core_v[k]) begin
          core_v[k] = 1'b0;
          if (drop_req) begin
            drop_req = 1'b0;
          end else begin
            cordic_valid  = 1'b1;
            cordic_rx     = core_x[k];
            cordic_ry     = core_y[k];
            cordic_rphase = core_p[k];
          end
        end
      end
    end
  end

  // Monitor: inflight tracked from accept history, responses popped from the scoreboard.
  initial begin
    int   ix;
    exp_t e;
    forever begin
      @(posedge in_clk);
      #1;
      if (!in_rst) begin
        for (int i = 0; i < 64; i++) acc_hist[i] = 1'b0;
        inf_m = 0;
      end else begin
        if (acc_hist[(cyc + 63) % 64]) inf_m++;
        ix = (cyc + 64 - RSP_LAT) % 64;
        if (acc_hist[ix]) begin
          inf_m--;
          acc_hist[ix] = 1'b0;
        end
        chk("inflight", 32'(inflight), 32'(inf_m));
        if (bus.rsp_valid !== '0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=%b, want none (cycle %0d)",
                     bus.rsp_valid, cyc);
          end else begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.id);
            chk("rsp_x", 32'(bus.rsp_x), 32'(e.x));
            chk("rsp_y", 32'(bus.rsp_y), 32'(e.y));
            chk("rsp_phase", 32'(bus.rsp_phase), 32'(e.ph));
            chk("rsp_cycle", 32'(cyc), 32'(e.due));
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_phase = '0;
    repeat (3) @(posedge in_clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_enable", 32'(cordic_enable), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_err", 32'(err_sticky), 32'h0);
    chk("rst_cordic_x", 32'(cordic_x), 32'h0);
    in_rst = 1'b1;
    @(posedge in_clk);
    #1;

    // All four held valid for 8 cycles from pointer 0.
    for (int k = 0; k < N; k++) begin
      set_ops(k, 16'h1000 + 16'(k * 16'h0111), 16'(16'h0200 * (k + 1)), 19'h10000 + 19'(k));
    end
    for (int i = 0; i < 8; i++) drive(4'b1111, 4'b0001 << (i % 4), 1'b1);
    chk("inflight_peak", 32'(inflight), 32'd8);
    idle(14);
    chk("inflight_drained", 32'(inflight), 32'd0);

    // Single op on requester 2; expected values worked out by hand.
    set_ops(2, 16'h1000, 16'h0000, 19'h0C90F);
    e.id  = 2;
    e.due = cyc + RSP_LAT;
    e.x   = 16'h4A5A;
    e.y   = 16'h1000;
    e.ph  = 19'h7C90F;
    sb.push_back(e);
    drive(4'b0100, 4'b0100, 1'b0);
    chk("single_enable", 32'(cordic_enable), 32'h1);
    drive(4'b0000, 4'b0000, 1'b0);
    chk("single_enable_pulse", 32'(cordic_enable), 32'h0);
    chk("single_cordic_x", 32'(cordic_x), 32'h1000);
    chk("single_cordic_y", 32'(cordic_y), 32'h0000);
    chk("single_cordic_phase", 32'(cordic_phase), 32'h0C90F);
    idle(13);

    // Pointer at 3: 1001 grants 3 then 0; idle holds the pointer at 1.
    drive(4'b1001, 4'b1000, 1'b1);
    drive(4'b1001, 4'b0001, 1'b1);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b1101, 4'b0100, 1'b1);
    idle(14);

    // Accept coinciding with a returning result keeps inflight unchanged.
    set_ops(1, 16'h0ABC, 16'h0123, 19'h01111);
    set_ops(3, 16'h7FFF, 16'h8000, 19'h7FFFF);
    drive(4'b0010, 4'b0010, 1'b1);
    idle(11);
    chk("inflight_pre_overlap", 32'(inflight), 32'd1);
    drive(4'b1000, 4'b1000, 1'b1);
    chk("inflight_overlap", 32'(inflight), 32'd1);
    idle(14);

    // Dropped core valid: error latches, response suppressed, later ops still routed.
    chk("err_before_drop", 32'(err_sticky), 32'h0);
    drop_req = 1'b1;
    drive(4'b0001, 4'b0001, 1'b0);
    idle(14);
    chk("err_after_drop", 32'(err_sticky), 32'h1);
    drive(4'b0100, 4'b0100, 1'b1);
    idle(14);
    chk("err_still_set", 32'(err_sticky), 32'h1);

    // Reset with five ops in flight.
    drive(4'b1111, 4'b1000, 1'b1);
    drive(4'b1111, 4'b0001, 1'b1);
    drive(4'b1111, 4'b0010, 1'b1);
    drive(4'b1111, 4'b0100, 1'b1);
    drive(4'b1111, 4'b1000, 1'b1);
    chk("inflight_before_rst", 32'(inflight), 32'd5);
    #2;
    in_rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_enable", 32'(cordic_enable), 32'h0);
    chk("mid_rst_inflight", 32'(inflight), 32'h0);
    chk("mid_rst_err", 32'(err_sticky), 32'h0);
    chk("mid_rst_rsp_x", 32'(bus.rsp_x), 32'h0);
    sb.delete();
    @(posedge in_clk);
    @(posedge in_clk);
    #2;
    in_rst = 1'b1;
    @(posedge in_clk);
    #1;
    idle(20);
    chk("post_rst_inflight", 32'(inflight), 32'd0);
    chk("post_rst_err", 32'(err_sticky), 32'h0);

    // Pointer restarts at 0 after reset.
    drive(4'b0110, 4'b0010, 1'b1);
    idle(14);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
